// File: rtl/score_display_mux_pkg.sv
// score_display_mux_pkg: shared constants, types and helpers for the score display
// Contents:
//   SCORE_W              width of one player score
//   SEG_BLANK/SEG_DIGIT  active-low {g,f,e,d,c,b,a} patterns
//   DIG_*                scan index of each digit position
//   flash_e              per-side flash FSM state
//   digit_of/seg_decode  binary-to-digit split and segment decoder
package score_display_mux_pkg;

    localparam int SCORE_W = 4;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Index 9 is leftmost so SEG_DIGIT[d] selects digit d
    localparam logic [9:0][6:0] SEG_DIGIT = {
        7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
        7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    // Bit 1 selects the side (1 = left), bit 0 selects tens
    localparam logic [1:0] DIG_R1  = 2'd0;
    localparam logic [1:0] DIG_R10 = 2'd1;
    localparam logic [1:0] DIG_L1  = 2'd2;
    localparam logic [1:0] DIG_L10 = 2'd3;

    typedef enum logic [1:0] {FL_IDLE, FL_OFF, FL_ON} flash_e;

    function automatic logic [3:0] digit_of(input logic [SCORE_W-1:0] s, input logic tens);
        return tens ? {3'd0, s >= 4'd10} : (s >= 4'd10 ? s - 4'd10 : s);
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        return d <= 4'd9 ? SEG_DIGIT[d] : SEG_BLANK;
    endfunction

endpackage

// File: rtl/score_display_mux_if.sv
// score_display_mux_if: score inputs from the game core and the display drive outputs
// Signals:
//   Score_Left, Score_Right  binary scores 0..15
//   an                       digit anodes, active low, an[3] leftmost
//   seg                      segments {g,f,e,d,c,b,a}, active low
//   dp                       decimal point, active low
// Modports: master = game/board side, slave = display mux
interface score_display_mux_if;
    import score_display_mux_pkg::*;

    logic [SCORE_W-1:0] Score_Left;
    logic [SCORE_W-1:0] Score_Right;
    logic [3:0]         an;
    logic [6:0]         seg;
    logic               dp;

    modport master (output Score_Left, output Score_Right, input an, input seg, input dp);
    modport slave  (input Score_Left, input Score_Right, output an, output seg, output dp);

endinterface

// File: rtl/score_display_mux_flash.sv
// score_flash_ctrl: flash sequencer for one side after its score changes
// Ports:
//   clk_lf      display clock
//   rst         synchronous active-high reset
//   score       registered score of this side
//   frame_tick  one pulse per display frame
//   blank       registered, high while this side's digits are dark
module score_flash_ctrl
    import score_display_mux_pkg::*;
#(
    parameter int FLASH_FRAMES = 64,
    parameter int FLASH_COUNT  = 3
) (
    input  logic               clk_lf,
    input  logic               rst,
    input  logic [SCORE_W-1:0] score,
    input  logic               frame_tick,
    output logic               blank
);

    localparam int FW = FLASH_FRAMES > 1 ? $clog2(FLASH_FRAMES) : 1;
    localparam int PW = FLASH_COUNT > 1 ? $clog2(FLASH_COUNT) : 1;

    flash_e             st;
    logic [SCORE_W-1:0] prev;
    logic [FW-1:0]      fcnt;
    logic [PW-1:0]      pairs;
    logic               changed;
    logic               half_done;

    assign changed   = score != prev;
    assign half_done = fcnt == FW'(FLASH_FRAMES - 1);

    always_ff @(posedge clk_lf) begin
        if (rst) begin
            st    <= FL_IDLE;
            prev  <= '0;
            fcnt  <= '0;
            pairs <= '0;
            blank <= 1'b0;
        end else begin
            prev <= score;
            // A change outranks a coincident frame tick: it restarts the sequence,
            // or cancels it outright when the new score is zero
            if (changed) begin
                st    <= score == 4'd0 ? FL_IDLE : FL_OFF;
                blank <= score != 4'd0;
                fcnt  <= '0;
                pairs <= '0;
            end else if (st != FL_IDLE && frame_tick) begin
                fcnt <= half_done ? '0 : fcnt + 1'b1;
                if (half_done) begin
                    if (st == FL_OFF) begin
                        st    <= FL_ON;
                        blank <= 1'b0;
                    end else if (pairs < PW'(FLASH_COUNT - 1)) begin
                        st    <= FL_OFF;
                        blank <= 1'b1;
                        pairs <= pairs + 1'b1;
                    end else begin
                        st <= FL_IDLE;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/score_display_mux.sv
// score_display_mux: scans two 4-bit scores onto a 4-digit multiplexed 7-segment display
// Ports:
//   clk_lf  display clock, single domain
//   rst     synchronous active-high reset
//   dsp     slave side of score_display_mux_if: Score_Left/Score_Right in, an/seg/dp out
// Left score on digits 3:2, right on 1:0; leading tens zero blanked; a side
// flashes after its score changes to a nonzero value.
module score_display_mux
    import score_display_mux_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int FLASH_FRAMES = 64,
    parameter int FLASH_COUNT  = 3
) (
    input logic                clk_lf,
    input logic                rst,
    score_display_mux_if.slave dsp
);

    localparam int CW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;

    logic [CW-1:0]      cnt;
    logic [1:0]         idx;
    logic [SCORE_W-1:0] score_l;
    logic [SCORE_W-1:0] score_r;
    logic [SCORE_W-1:0] score_sel;
    logic [3:0]         digit;
    logic [3:0]         an_d;
    logic [6:0]         seg_d;
    logic               dp_d;
    logic               tc;
    logic               frame_tick;
    logic               blank_l;
    logic               blank_r;
    logic               side_blank;

    assign tc         = cnt == CW'(REFRESH_DIV - 1);
    assign frame_tick = tc && idx == DIG_L10;

    score_flash_ctrl #(.FLASH_FRAMES(FLASH_FRAMES), .FLASH_COUNT(FLASH_COUNT)) u_flash_l (
        .clk_lf     (clk_lf),
        .rst        (rst),
        .score      (score_l),
        .frame_tick (frame_tick),
        .blank      (blank_l)
    );

    score_flash_ctrl #(.FLASH_FRAMES(FLASH_FRAMES), .FLASH_COUNT(FLASH_COUNT)) u_flash_r (
        .clk_lf     (clk_lf),
        .rst        (rst),
        .score      (score_r),
        .frame_tick (frame_tick),
        .blank      (blank_r)
    );

    // idx[1] picks the side and idx[0] the tens digit, matching the DIG_* encoding
    always_comb begin
        score_sel  = idx[1] ? score_l : score_r;
        side_blank = idx[1] ? blank_l : blank_r;
        digit      = digit_of(score_sel, idx[0]);
        seg_d      = side_blank || (idx[0] && digit == 4'd0) ? SEG_BLANK : seg_decode(digit);
        an_d       = ~(4'b0001 << idx);
        dp_d       = idx != DIG_L1 || blank_l;
    end

    always_ff @(posedge clk_lf) begin
        if (rst) begin
            score_l <= '0;
            score_r <= '0;
            cnt     <= '0;
            idx     <= DIG_R1;
            dsp.an  <= 4'b1111;
            dsp.seg <= SEG_BLANK;
            dsp.dp  <= 1'b1;
        end else begin
            score_l <= dsp.Score_Left;
            score_r <= dsp.Score_Right;
            cnt     <= tc ? '0 : cnt + 1'b1;
            if (tc)
                idx <= idx + 2'd1;
            dsp.an  <= an_d;
            dsp.seg <= seg_d;
            dsp.dp  <= dp_d;
        end
    end

endmodule
